// File: rtl/parity_uart_rx.sv
// rtl/parity_uart_rx.sv - serial frame receiver with parity/framing check, error count and good-frame led
//
// Frame on the line: start(0), DATA_BITS data bits LSB first, parity bit, stop(1).
// Each completed frame is presented with a one-cycle valid strobe.
//
// Parameters
//   CLKS_PER_BIT  sys_clk cycles per serial bit (>= 4)
//   DATA_BITS     data bits per frame (1..16)
//   ODD_PARITY    0 = even parity, 1 = odd parity
//
// Ports
//   sys_clk     in   single clock, rising edge
//   reset       in   synchronous active-high reset
//   rx          in   asynchronous serial line, idles high
//   data        out  last received word, held until the next valid
//   valid       out  one-cycle strobe marking a completed frame
//   parity_err  out  parity mismatch for the word shown with valid, held
//   frame_err   out  stop bit sampled low for that frame, held
//   busy        out  high whenever the receiver is not idle
//   err_count   out  frames with any error, saturating at 255
//   led         out  toggles on each error-free frame

module parity_uart_rx #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8,
    parameter int ODD_PARITY   = 0
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy,
    output logic [7:0]           err_count,
    output logic                 led
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST      = BW'(DATA_BITS - 1);
    localparam logic          PARITY_SENSE  = (ODD_PARITY != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t state;
    state_t state_next;

    // Two-flop synchroniser; both flops idle high so reset never looks like a start edge.
    logic rx_meta;
    logic rx_s;

    logic [CW-1:0]        clk_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic                 parity_bit;

    logic bit_tick;
    logic cnt_clear;
    logic shift_en;
    logic parity_en;
    logic frame_done;
    logic parity_bad;
    logic stop_bad;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign bit_tick = (clk_cnt == CNT_BIT_LAST);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        shift_en   = 1'b0;
        parity_en  = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    cnt_clear  = 1'b1;
                end
            end
            START: begin
                // Mid-bit re-check of the start bit rejects short glitches.
                if (clk_cnt == CNT_HALF_LAST) begin
                    cnt_clear  = 1'b1;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    cnt_clear = 1'b1;
                    shift_en  = 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    cnt_clear  = 1'b1;
                    parity_en  = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit lets an immediately following start edge be caught.
                if (bit_tick) begin
                    cnt_clear  = 1'b1;
                    frame_done = 1'b1;
                    state_next = rx_s ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                // A stuck-low line must go high before any new start is accepted.
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // New bit enters at the MSB; after DATA_BITS shifts the first (LSB) bit sits at bit 0.
    always_comb begin
        shift_next                = shift_reg >> 1;
        shift_next[DATA_BITS-1]   = rx_s;
    end

    assign parity_bad = (^{shift_reg, parity_bit}) ^ PARITY_SENSE;
    assign stop_bad   = ~rx_s;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            if (cnt_clear || state == IDLE || state == WAIT_IDLE) begin
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end
            if (state != DATA) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else begin
            if (shift_en) begin
                shift_reg <= shift_next;
            end
            if (parity_en) begin
                parity_bit <= rx_s;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            err_count  <= 8'd0;
            led        <= 1'b0;
        end else begin
            valid <= frame_done;
            if (frame_done) begin
                data       <= shift_reg;
                parity_err <= parity_bad;
                frame_err  <= stop_bad;
                if (parity_bad || stop_bad) begin
                    if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                end else begin
                    led <= ~led;
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_parity_uart_rx.sv
// tb/tb_parity_uart_rx.sv - directed self-checking bench for parity_uart_rx

module tb_parity_uart_rx;

    localparam int CPB = 10;

    logic       sys_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       rx      = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;
    logic [7:0] err_count;
    logic       led;

    int total = 0;
    int bad   = 0;

    int cyc      = 0;
    int vcount   = 0;
    int last_vcyc = 0;
    logic [9:0] vq[$];

    parity_uart_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS(8),
        .ODD_PARITY(0)
    ) dut (
        .sys_clk(sys_clk),
        .reset(reset),
        .rx(rx),
        .data(data),
        .valid(valid),
        .parity_err(parity_err),
        .frame_err(frame_err),
        .busy(busy),
        .err_count(err_count),
        .led(led)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (valid === 1'b1) begin
            vq.push_back({frame_err, parity_err, data});
            vcount    <= vcount + 1;
            last_vcyc <= cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge sys_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic check_entry(input string tag, input logic [9:0] exp);
        logic [9:0] e;
        if (vq.size() == 0) begin
            check({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            e = vq.pop_front();
            check(tag, {22'd0, e}, {22'd0, exp});
        end
    endtask

    int n0;
    int t0;
    int lat;
    logic got;

    initial begin
        repeat (4) @(negedge sys_clk);
        reset = 1'b0;
        @(negedge sys_clk);

        // reset state
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_errs", {30'd0, parity_err, frame_err}, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);
        check("rst_led", {31'd0, led}, 32'd0);
        idle(20);

        // 1: good frame 0xA5
        n0 = vcount;
        t0 = cyc;
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(20);
        check("t1_valids", vcount, n0 + 1);
        check_entry("t1_entry", {2'b00, 8'hA5});
        lat = last_vcyc - t0;
        check("t1_latency_window", {31'd0, (lat >= 105 && lat <= 111)}, 32'd1);
        check("t1_led", {31'd0, led}, 32'd1);
        check("t1_err_count", {24'd0, err_count}, 32'd0);

        // 2: parity error on 0x01
        n0 = vcount;
        send_frame(8'h01, 1'b0, 1'b1);
        idle(20);
        check("t2_valids", vcount, n0 + 1);
        check_entry("t2_entry", {2'b01, 8'h01});
        check("t2_err_count", {24'd0, err_count}, 32'd1);
        check("t2_led", {31'd0, led}, 32'd1);

        // 3: 3-clock glitch
        n0 = vcount;
        rx = 1'b0;
        repeat (3) @(negedge sys_clk);
        rx = 1'b1;
        got = 1'b0;
        for (int i = 0; i < CPB / 2 + 3; i++) begin
            @(negedge sys_clk);
            if (busy === 1'b0) got = 1'b1;
        end
        check("t3_busy_cleared", {31'd0, got}, 32'd1);
        idle(30);
        check("t3_no_valid", vcount, n0);
        check("t3_outputs", {20'd0, parity_err, frame_err, led, err_count, data[0]},
              {20'd0, 1'b1, 1'b0, 1'b1, 8'd1, 1'b1});
        check("t3_data", {24'd0, data}, 32'h01);

        // 4: stop bit low, line held low 40 clocks
        n0 = vcount;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(8'h3C >> i);
        send_bit(1'b0);
        rx = 1'b0;
        repeat (40) @(negedge sys_clk);
        check("t4_valids", vcount, n0 + 1);
        check_entry("t4_entry", {2'b10, 8'h3C});
        check("t4_err_count", {24'd0, err_count}, 32'd2);
        check("t4_busy_held", {31'd0, busy}, 32'd1);
        check("t4_led", {31'd0, led}, 32'd1);
        idle(10);
        check("t4_busy_released", {31'd0, busy}, 32'd0);
        n0 = vcount;
        send_frame(8'h5A, 1'b0, 1'b1);
        idle(20);
        check("t4_next_valids", vcount, n0 + 1);
        check_entry("t4_next_entry", {2'b00, 8'h5A});
        check("t4_next_led", {31'd0, led}, 32'd0);

        // 5: reset during the 4th data bit of 0xFF
        n0 = vcount;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rx = 1'b1;
        repeat (4) @(negedge sys_clk);
        reset = 1'b1;
        @(negedge sys_clk);
        reset = 1'b0;
        check("t5_rst_data", {24'd0, data}, 32'd0);
        check("t5_rst_flags", {28'd0, valid, busy, parity_err, frame_err}, 32'd0);
        check("t5_rst_err_count", {24'd0, err_count}, 32'd0);
        check("t5_rst_led", {31'd0, led}, 32'd0);
        idle(120);
        check("t5_no_valid", vcount, n0);
        send_frame(8'h55, 1'b0, 1'b1);
        idle(20);
        check("t5_next_valids", vcount, n0 + 1);
        check_entry("t5_next_entry", {2'b00, 8'h55});
        check("t5_next_led", {31'd0, led}, 32'd1);

        // 6: back-to-back frames
        n0 = vcount;
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'h81, 1'b0, 1'b1);
        idle(20);
        check("t6_valids", vcount, n0 + 3);
        check_entry("t6_entry0", {2'b00, 8'h00});
        check_entry("t6_entry1", {2'b00, 8'hFF});
        check_entry("t6_entry2", {2'b00, 8'h81});
        check("t6_led", {31'd0, led}, 32'd0);
        check("t6_err_count", {24'd0, err_count}, 32'd0);

        // err_count saturation
        n0 = vcount;
        for (int i = 0; i < 255; i++) send_frame(8'h01, 1'b0, 1'b1);
        idle(20);
        check("sat_255", {24'd0, err_count}, 32'd255);
        send_frame(8'h01, 1'b0, 1'b1);
        idle(20);
        check("sat_hold", {24'd0, err_count}, 32'd255);
        check("sat_valids", vcount, n0 + 256);
        check("sat_led", {31'd0, led}, 32'd0);
        vq.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
